// File: rtl/sync_fifo_flex_pkg.sv
// Shared FIFO types for the QSPI TX/RX data-path wrappers.
// Holds the read-mode selector and the elaboration-time depth check.
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic bit is_pow2_ge2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// Push/pop/status bundle of sync_fifo_flex; the producer/consumer side uses
// the master modport and the FIFO uses the slave modport.
interface sync_fifo_flex_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [LW-1:0]         level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en, err_clr,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en, err_clr,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// Storage array for sync_fifo_flex: one synchronous write port and one
// asynchronous read port; contents are deliberately not reset.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with registered or show-ahead read, programmable almost
// thresholds, fill level, synchronous flush and sticky overflow/underflow.
module sync_fifo_flex
  import fifo_pkg::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         FIFO_DEPTH    = 16,
  parameter fifo_mode_e READ_MODE     = FIFO_STD,
  parameter int         AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int         AEMPTY_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_flex_if.slave  bus
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  if (!is_pow2_ge2(FIFO_DEPTH)) begin : g_bad_depth
    $error("sync_fifo_flex: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("sync_fifo_flex: AFULL_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("sync_fifo_flex: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop_ok;
  logic                  w_push_ok;
  logic                  w_ovf_set;
  logic                  w_unf_set;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Status flags decode from the registered level only.
  assign w_full  = (r_level == LW'(FIFO_DEPTH));
  assign w_empty = (r_level == '0);

  assign w_pop_ok  = !bus.flush && bus.rd_en && !w_empty;
  assign w_push_ok = !bus.flush && bus.wr_en && (!w_full || w_pop_ok);
  assign w_ovf_set = !bus.flush && bus.wr_en && !w_push_ok;
  assign w_unf_set = !bus.flush && bus.rd_en && !w_pop_ok;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .AW         (AW)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr),
    .i_wdata (bus.wr_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (bus.flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_level <= r_level + LW'(1);
      else if (!w_push_ok && w_pop_ok) r_level <= r_level - LW'(1);
      r_rd_valid <= w_pop_ok;
      if (w_pop_ok) r_rd_data <= w_rdata;
    end
  end

  // A new error event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set)        r_overflow <= 1'b1;
      else if (bus.err_clr) r_overflow <= 1'b0;
      if (w_unf_set)        r_underflow <= 1'b1;
      else if (bus.err_clr) r_underflow <= 1'b0;
    end
  end

  assign bus.rd_data      = (READ_MODE == FIFO_FWFT) ? w_rdata  : r_rd_data;
  assign bus.rd_valid     = (READ_MODE == FIFO_FWFT) ? !w_empty : r_rd_valid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_level >= LW'(AFULL_THRESH));
  assign bus.almost_empty = (r_level <= LW'(AEMPTY_THRESH));
  assign bus.level        = r_level;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: one STD and one FWFT instance (DEPTH=16) checked
// against queue scoreboards filled on push and drained on pop.
module tb_sync_fifo_flex;
  import fifo_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) s_if ();
  sync_fifo_flex_if #(.DATA_WIDTH(32), .FIFO_DEPTH(16)) f_if ();

  sync_fifo_flex #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .READ_MODE(FIFO_STD)) u_std (
    .clk (clk), .rst (rst), .bus (s_if)
  );
  sync_fifo_flex #(.DATA_WIDTH(32), .FIFO_DEPTH(16), .READ_MODE(FIFO_FWFT)) u_fwft (
    .clk (clk), .rst (rst), .bus (f_if)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] q_std[$];
  logic [31:0] q_fw[$];
  bit          sv_exp;
  logic [31:0] sd_exp;
  bit          s_ovf, s_unf;

  task automatic idle_inputs();
    s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.flush = 1'b0; s_if.err_clr = 1'b0;
    s_if.wr_data = '0;
    f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.flush = 1'b0; f_if.err_clr = 1'b0;
    f_if.wr_data = '0;
  endtask

  // One STD clock: drive, take the edge, then advance the scoreboard.
  task automatic std_cycle(input bit wr, input logic [31:0] d, input bit rd,
                           input bit fl, input bit ec);
    bit pop_ok, push_ok;
    pop_ok  = !fl && rd && (q_std.size() != 0);
    push_ok = !fl && wr && ((q_std.size() != 16) || pop_ok);
    s_if.wr_en = wr; s_if.wr_data = d; s_if.rd_en = rd; s_if.flush = fl; s_if.err_clr = ec;
    @(posedge clk); #1;
    s_ovf  = (!fl && wr && !push_ok) ? 1'b1 : (ec ? 1'b0 : s_ovf);
    s_unf  = (!fl && rd && !pop_ok)  ? 1'b1 : (ec ? 1'b0 : s_unf);
    sv_exp = pop_ok;
    if (pop_ok)  sd_exp = q_std.pop_front();
    if (push_ok) q_std.push_back(d);
    if (fl)      q_std.delete();
    idle_inputs();
  endtask

  task automatic fwft_cycle(input bit wr, input logic [31:0] d, input bit rd, input bit fl);
    bit pop_ok, push_ok;
    pop_ok  = !fl && rd && (q_fw.size() != 0);
    push_ok = !fl && wr && ((q_fw.size() != 16) || pop_ok);
    f_if.wr_en = wr; f_if.wr_data = d; f_if.rd_en = rd; f_if.flush = fl;
    @(posedge clk); #1;
    if (pop_ok)  void'(q_fw.pop_front());
    if (push_ok) q_fw.push_back(d);
    if (fl)      q_fw.delete();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (s_if.level !== 5'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", s_if.level); end
    n_cmp++; if (s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1) begin n_bad++;
      $display("FAIL reset_empty got empty=%b aempty=%b want 1/1", s_if.empty, s_if.almost_empty); end
    n_cmp++; if (s_if.full !== 1'b0 || s_if.almost_full !== 1'b0) begin n_bad++;
      $display("FAIL reset_full got full=%b afull=%b want 0/0", s_if.full, s_if.almost_full); end
    n_cmp++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0) begin n_bad++;
      $display("FAIL reset_err got ovf=%b unf=%b want 0/0", s_if.overflow, s_if.underflow); end
    n_cmp++; if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 32'h0) begin n_bad++;
      $display("FAIL reset_rd got v=%b d=%h want 0/0", s_if.rd_valid, s_if.rd_data); end
    n_cmp++; if (f_if.rd_valid !== 1'b0 || f_if.empty !== 1'b1) begin n_bad++;
      $display("FAIL reset_fwft got v=%b empty=%b want 0/1", f_if.rd_valid, f_if.empty); end
    rst = 1'b0;
    sv_exp = 1'b0; sd_exp = '0; s_ovf = 1'b0; s_unf = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      std_cycle(1'b1, 32'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (s_if.level !== 5'(i + 1)) begin n_bad++;
        $display("FAIL fill_level got %0d want %0d", s_if.level, i + 1); end
      n_cmp++; if (s_if.almost_full !== (i + 1 >= 14) || s_if.full !== (i + 1 == 16)) begin n_bad++;
        $display("FAIL fill_flags lvl=%0d got afull=%b full=%b", i + 1, s_if.almost_full, s_if.full); end
      n_cmp++; if (s_if.almost_empty !== (i + 1 <= 2)) begin n_bad++;
        $display("FAIL fill_aempty lvl=%0d got %b", i + 1, s_if.almost_empty); end
    end
    for (int i = 0; i < 16; i++) begin
      std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== sd_exp || sd_exp !== 32'(i)) begin n_bad++;
        $display("FAIL drain_data got v=%b d=%h want 1/%h", s_if.rd_valid, s_if.rd_data, i); end
    end
    std_cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (s_if.empty !== 1'b1 || s_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL drain_end got empty=%b v=%b want 1/0", s_if.empty, s_if.rd_valid); end
  endtask

  task automatic test_fwft_latency();
    fwft_cycle(1'b1, 32'hA5A5A5A5, 1'b0, 1'b0);
    n_cmp++; if (f_if.rd_valid !== 1'b1 || f_if.rd_data !== 32'hA5A5A5A5) begin n_bad++;
      $display("FAIL fwft_latency got v=%b d=%h want 1/a5a5a5a5", f_if.rd_valid, f_if.rd_data); end
    fwft_cycle(1'b0, '0, 1'b1, 1'b0);
    n_cmp++; if (f_if.empty !== 1'b1 || f_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL fwft_pop got empty=%b v=%b want 1/0", f_if.empty, f_if.rd_valid); end
  endtask

  task automatic test_back_to_back();
    fwft_cycle(1'b1, 32'h1000, 1'b0, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      fwft_cycle(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
      n_cmp++; if (f_if.level !== 5'd1 || f_if.rd_data !== q_fw[0]) begin n_bad++;
        $display("FAIL b2b_fwft got lvl=%0d d=%h want 1/%h", f_if.level, f_if.rd_data, q_fw[0]); end
    end
    fwft_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 16; i++) std_cycle(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (s_if.level !== 5'd16 || s_if.overflow !== 1'b0) begin n_bad++;
      $display("FAIL full_pp got lvl=%0d ovf=%b want 16/0", s_if.level, s_if.overflow); end
    n_cmp++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== sd_exp) begin n_bad++;
      $display("FAIL full_pp_data got v=%b d=%h want 1/%h", s_if.rd_valid, s_if.rd_data, sd_exp); end
    for (int i = 0; i < 16; i++) begin
      std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== sd_exp) begin n_bad++;
        $display("FAIL full_pp_drain got v=%b d=%h want 1/%h", s_if.rd_valid, s_if.rd_data, sd_exp); end
    end
    n_cmp++; if (s_if.rd_data !== 32'h55) begin n_bad++;
      $display("FAIL full_pp_last got %h want 00000055", s_if.rd_data); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 16; i++) std_cycle(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (s_if.overflow !== 1'b1 || s_if.level !== 5'd16) begin n_bad++;
      $display("FAIL ovf_set got ovf=%b lvl=%0d want 1/16", s_if.overflow, s_if.level); end
    std_cycle(1'b1, 32'hBEEF, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (s_if.overflow !== 1'b1) begin n_bad++;
      $display("FAIL ovf_set_wins got %b want 1", s_if.overflow); end
    std_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (s_if.overflow !== 1'b0) begin n_bad++;
      $display("FAIL ovf_clr got %b want 0", s_if.overflow); end
    for (int i = 0; i < 16; i++) begin
      std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (s_if.rd_data !== sd_exp || sd_exp !== 32'h200 + 32'(i)) begin n_bad++;
        $display("FAIL err_drain got %h want %h", s_if.rd_data, 32'h200 + 32'(i)); end
    end
    std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (s_if.underflow !== 1'b1 || s_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL unf_set got unf=%b v=%b want 1/0", s_if.underflow, s_if.rd_valid); end
    std_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    std_cycle(1'b1, 32'h77, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (s_if.underflow !== 1'b1 || s_if.level !== 5'd1 || s_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL unf_with_push got unf=%b lvl=%0d v=%b want 1/1/0", s_if.underflow, s_if.level, s_if.rd_valid); end
    std_cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (s_if.underflow !== s_unf || s_if.rd_data !== 32'h77) begin n_bad++;
      $display("FAIL unf_clr_pop got unf=%b d=%h want %b/00000077", s_if.underflow, s_if.rd_data, s_unf); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) std_cycle(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0, 1'b0);
    n_cmp++; if (s_if.level !== 5'd7) begin n_bad++;
      $display("FAIL flush_pre got %0d want 7", s_if.level); end
    std_cycle(1'b1, 32'h999, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (s_if.level !== 5'd0 || s_if.empty !== 1'b1 || s_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_state got lvl=%0d empty=%b v=%b want 0/1/0", s_if.level, s_if.empty, s_if.rd_valid); end
    n_cmp++; if (s_if.overflow !== 1'b0 || s_if.underflow !== 1'b0 || s_if.rd_data !== sd_exp) begin n_bad++;
      $display("FAIL flush_hold got ovf=%b unf=%b d=%h want 0/0/%h", s_if.overflow, s_if.underflow, s_if.rd_data, sd_exp); end
    for (int i = 0; i < 3; i++) fwft_cycle(1'b1, 32'h400 + 32'(i), 1'b0, 1'b0);
    fwft_cycle(1'b1, 32'h999, 1'b1, 1'b1);
    n_cmp++; if (f_if.empty !== 1'b1 || f_if.rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL flush_fwft got empty=%b v=%b want 1/0", f_if.empty, f_if.rd_valid); end
  endtask

  task automatic test_wraparound();
    for (int i = 0; i < 40; i++) begin
      std_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      n_cmp++; if (s_if.rd_valid !== sv_exp || (sv_exp && s_if.rd_data !== sd_exp)
                   || s_if.level !== 5'(q_std.size())) begin n_bad++;
        $display("FAIL wrap_std op=%0d got v=%b d=%h lvl=%0d want %b/%h/%0d", i, s_if.rd_valid,
                 s_if.rd_data, s_if.level, sv_exp, sd_exp, q_std.size()); end
    end
    for (int i = 0; i < 40; i++) begin
      fwft_cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) == 1, 1'b0);
      n_cmp++; if (f_if.rd_valid !== (q_fw.size() != 0) || f_if.level !== 5'(q_fw.size())
                   || (q_fw.size() != 0 && f_if.rd_data !== q_fw[0])) begin n_bad++;
        $display("FAIL wrap_fwft op=%0d got v=%b d=%h lvl=%0d want lvl=%0d", i, f_if.rd_valid,
                 f_if.rd_data, f_if.level, q_fw.size()); end
    end
    while (q_std.size() != 0) std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    while (q_fw.size() != 0)  fwft_cycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    std_cycle(1'b1, 32'h501, 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h502, 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h503, 1'b1, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h504, 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h505, 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'h506, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (s_if.level !== 5'd5) begin n_bad++;
      $display("FAIL rstmid_pre got %0d want 5", s_if.level); end
    s_if.wr_en = 1'b1; s_if.wr_data = 32'h507; s_if.rd_en = 1'b1;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (s_if.level !== 5'd0 || s_if.empty !== 1'b1 || s_if.almost_empty !== 1'b1
                 || s_if.full !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_status got lvl=%0d empty=%b ae=%b full=%b", s_if.level, s_if.empty,
               s_if.almost_empty, s_if.full); end
    n_cmp++; if (s_if.rd_valid !== 1'b0 || s_if.rd_data !== 32'h0) begin n_bad++;
      $display("FAIL rstmid_rd got v=%b d=%h want 0/0", s_if.rd_valid, s_if.rd_data); end
    q_std.delete(); q_fw.delete();
    sv_exp = 1'b0; sd_exp = '0; s_ovf = 1'b0; s_unf = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    std_cycle(1'b1, 32'hC0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (s_if.level !== 5'd1) begin n_bad++;
      $display("FAIL rstmid_first_push got %0d want 1", s_if.level); end
    std_cycle(1'b1, 32'hC1, 1'b0, 1'b0, 1'b0);
    std_cycle(1'b1, 32'hC2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      std_cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (s_if.rd_valid !== 1'b1 || s_if.rd_data !== 32'hC0 + 32'(i)) begin n_bad++;
        $display("FAIL rstmid_data got v=%b d=%h want 1/%h", s_if.rd_valid, s_if.rd_data, 32'hC0 + 32'(i)); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_fwft_latency();
    test_back_to_back();
    test_full_push_pop();
    test_errors();
    test_flush();
    test_wraparound();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
